// File: rtl/kid_motion.sv
// kid_motion: per-frame movement engine for the kid sprite.
// Each frame_tick starts one motion pass that walks the sprite one pixel per
// clock so the downstream collision detector sees every intermediate position,
// and stops horizontal or vertical motion as soon as a blocked edge is flagged.
module kid_motion #(
  parameter int KID_W    = 11,
  parameter int KID_H    = 21,
  parameter int START_X  = 40,
  parameter int START_Y  = 396,
  parameter int WALK_SPD = 3,
  parameter int JUMP_V   = 8,
  parameter int JUMP2_V  = 7,
  parameter int GRAVITY  = 1,
  parameter int MAX_FALL = 9
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_jump,
  input  logic [3:0] is_collide,
  output logic [9:0] kid_t,
  output logic [9:0] kid_b,
  output logic [9:0] kid_l,
  output logic [9:0] kid_r,
  output logic       kid_dir,
  output logic       on_ground,
  output logic       busy
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CALC  = 3'd1;
  localparam logic [2:0] S_HMOVE = 3'd2;
  localparam logic [2:0] S_VMOVE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [9:0]        X_RESET  = 10'(START_X);
  localparam logic [9:0]        Y_RESET  = 10'(START_Y);
  localparam logic [9:0]        X_MAX    = 10'(799 - KID_W);
  localparam logic [9:0]        W_OFS    = 10'(KID_W);
  localparam logic [9:0]        H_OFS    = 10'(KID_H);
  localparam logic [3:0]        H_STEPS  = 4'(WALK_SPD);
  localparam logic signed [5:0] VY_JUMP1 = 6'(-JUMP_V);
  localparam logic signed [5:0] VY_JUMP2 = 6'(-JUMP2_V);
  localparam logic signed [5:0] VY_MAXF  = 6'(MAX_FALL);
  localparam logic signed [6:0] VY_MAXF7 = 7'(MAX_FALL);
  localparam logic [6:0]        VY_GRAV7 = 7'(GRAVITY);

  // Architectural state
  logic [2:0]        r_state;
  logic [9:0]        r_x;
  logic [9:0]        r_y;
  logic signed [5:0] r_vy;
  logic              r_jumps_left;
  logic              r_on_ground;
  logic              r_dir;
  logic              r_jump_prev;
  logic              r_jump_req;

  // Per-pass working registers
  logic              r_btn_l;
  logic              r_btn_r;
  logic              r_hright;
  logic [3:0]        r_hcnt;
  logic [5:0]        r_vcnt;

  // CALC results
  logic              w_hdir_r;
  logic              w_hdir_l;
  logic signed [6:0] w_vy_grav;
  logic signed [5:0] w_vy_fall;
  logic signed [5:0] w_vy_new;
  logic              w_jl_new;
  logic [5:0]        w_vcnt_new;

  // Move-phase conditions
  logic              w_hblock;
  logic              w_hlimit;
  logic              w_vy_up;
  logic              w_vy_down;
  logic              w_vstop;

  // Compute the new velocity, jump bookkeeping and step counts for CALC
  always_comb begin
    w_hdir_r   = r_btn_r & ~r_btn_l;
    w_hdir_l   = r_btn_l & ~r_btn_r;
    w_vy_grav  = {r_vy[5], r_vy} + VY_GRAV7;
    w_vy_fall  = (w_vy_grav > VY_MAXF7) ? VY_MAXF : w_vy_grav[5:0];
    w_vy_new   = '0;
    w_jl_new   = r_jumps_left;
    if (r_jump_req && r_on_ground) begin
      w_vy_new = VY_JUMP1;
      w_jl_new = 1'b1;
    end else if (r_jump_req && r_jumps_left) begin
      w_vy_new = VY_JUMP2;
      w_jl_new = 1'b0;
    end else if (!r_on_ground) begin
      w_vy_new = w_vy_fall;
    end
    w_vcnt_new = w_vy_new[5] ? 6'(-w_vy_new) : 6'(w_vy_new);
  end

  // Decode blocking and screen-limit conditions for the current move step
  always_comb begin
    w_hblock  = r_hright ? is_collide[0] : is_collide[1];
    w_hlimit  = r_hright ? (r_x >= X_MAX) : (r_x == '0);
    w_vy_up   = r_vy[5];
    w_vy_down = !r_vy[5] && (r_vy != '0);
    w_vstop   = (w_vy_up && (is_collide[3] || (r_y == '0))) ||
                (w_vy_down && is_collide[2]);
  end

  // Jump button edge detect; a pending request survives until CALC consumes it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_jump_prev <= 1'b0;
      r_jump_req  <= 1'b0;
    end else begin
      r_jump_prev <= btn_jump;
      if (btn_jump && !r_jump_prev) begin
        r_jump_req <= 1'b1;
      end else if (r_state == S_CALC) begin
        r_jump_req <= 1'b0;
      end
    end
  end

  // Motion pass FSM and position/velocity datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_x          <= X_RESET;
      r_y          <= Y_RESET;
      r_vy         <= '0;
      r_jumps_left <= 1'b0;
      r_on_ground  <= 1'b0;
      r_dir        <= 1'b1;
      r_btn_l      <= 1'b0;
      r_btn_r      <= 1'b0;
      r_hright     <= 1'b1;
      r_hcnt       <= '0;
      r_vcnt       <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (frame_tick) begin
            r_btn_l <= btn_left;
            r_btn_r <= btn_right;
            r_state <= S_CALC;
          end
        end

        S_CALC: begin
          if (w_hdir_r || w_hdir_l) begin
            r_dir    <= w_hdir_r;
            r_hright <= w_hdir_r;
            r_hcnt   <= H_STEPS;
          end else begin
            r_hcnt   <= '0;
          end
          r_vy         <= w_vy_new;
          r_jumps_left <= w_jl_new;
          r_vcnt       <= w_vcnt_new;
          r_state      <= S_HMOVE;
        end

        S_HMOVE: begin
          if ((r_hcnt == '0) || w_hblock || w_hlimit) begin
            r_state <= S_VMOVE;
          end else begin
            r_x    <= r_hright ? (r_x + 10'd1) : (r_x - 10'd1);
            r_hcnt <= r_hcnt - 4'd1;
          end
        end

        S_VMOVE: begin
          if (w_vstop) begin
            r_vy    <= '0;
            r_state <= S_DONE;
          end else if (r_vcnt == '0) begin
            r_state <= S_DONE;
          end else begin
            r_y    <= w_vy_up ? (r_y - 10'd1) : (r_y + 10'd1);
            r_vcnt <= r_vcnt - 6'd1;
          end
        end

        S_DONE: begin
          // Walking off a ledge leaves jumps_left alone: one air jump remains.
          r_on_ground <= is_collide[2];
          if (is_collide[2]) begin
            r_jumps_left <= 1'b1;
          end
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Sprite bounds and status outputs
  always_comb begin
    kid_t     = r_y;
    kid_b     = r_y + H_OFS;
    kid_l     = r_x;
    kid_r     = r_x + W_OFS;
    kid_dir   = r_dir;
    on_ground = r_on_ground;
    busy      = (r_state != S_IDLE);
  end

endmodule

// File: tb/tb_kid_motion.sv
// Bench for kid_motion: directed frames with hand-computed end positions,
// checked by a monitor that pops an expectation each time a pass completes.
module tb_kid_motion;

  logic       clk        = 1'b0;
  logic       rst_n      = 1'b0;
  logic       frame_tick = 1'b0;
  logic       btn_left   = 1'b0;
  logic       btn_right  = 1'b0;
  logic       btn_jump   = 1'b0;
  logic [3:0] is_collide;
  logic [9:0] kid_t, kid_b, kid_l, kid_r;
  logic       kid_dir, on_ground, busy;

  // Simple collision environment: floor, right wall, ceiling
  logic       floor_en = 1'b0;
  int         floor_y  = 1000;
  logic       wallr_en = 1'b0;
  int         wallr_x  = 1000;
  logic       ceil_en  = 1'b0;
  int         ceil_y   = 0;

  typedef struct {
    int x;
    int y;
    int dir;
    int og;
    int lat;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   n_checks  = 0;
  int   n_pass    = 0;
  int   mon_lat   = 0;
  int   mon_npass = 0;
  logic mon_prev  = 1'b0;
  int   yexp;
  int   vyexp;

  kid_motion dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_tick (frame_tick),
    .btn_left   (btn_left),
    .btn_right  (btn_right),
    .btn_jump   (btn_jump),
    .is_collide (is_collide),
    .kid_t      (kid_t),
    .kid_b      (kid_b),
    .kid_l      (kid_l),
    .kid_r      (kid_r),
    .kid_dir    (kid_dir),
    .on_ground  (on_ground),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  assign is_collide = {ceil_en  && (int'(kid_t) <= ceil_y),
                       floor_en && (int'(kid_b) >= floor_y),
                       1'b0,
                       wallr_en && (int'(kid_r) >= wallr_x)};

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  task automatic wait_drain();
    int t = 0;
    while (q.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (q.size() != 0) begin
      check("pass_timeout", q.size(), 0);
      q.delete();
    end
    @(negedge clk);
  endtask

  task automatic expect_pass(input int x, input int y, input int dir,
                             input int og, input int lat);
    exp_t e;
    e.x = x; e.y = y; e.dir = dir; e.og = og; e.lat = lat;
    q.push_back(e);
  endtask

  task automatic tick();
    @(negedge clk) frame_tick = 1'b1;
    @(negedge clk) frame_tick = 1'b0;
  endtask

  task automatic do_frame(input int x, input int y, input int dir,
                          input int og, input int lat);
    expect_pass(x, y, dir, og, lat);
    tick();
    wait_drain();
  endtask

  task automatic tap_jump();
    @(negedge clk) btn_jump = 1'b1;
    @(negedge clk) btn_jump = 1'b0;
  endtask

  // Monitor: a falling busy marks the end of a pass
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mon_prev = 1'b0;
        mon_lat  = 0;
      end else begin
        if (busy) mon_lat++;
        if (mon_prev && !busy) begin
          mon_npass++;
          if (q.size() == 0) begin
            check($sformatf("unexpected_pass%0d", mon_npass), 1, 0);
          end else begin
            mon_e = q.pop_front();
            check($sformatf("p%0d_kid_l", mon_npass), int'(kid_l), mon_e.x);
            check($sformatf("p%0d_kid_r", mon_npass), int'(kid_r), mon_e.x + 11);
            check($sformatf("p%0d_kid_t", mon_npass), int'(kid_t), mon_e.y);
            check($sformatf("p%0d_kid_b", mon_npass), int'(kid_b), mon_e.y + 21);
            check($sformatf("p%0d_dir", mon_npass), int'(kid_dir), mon_e.dir);
            check($sformatf("p%0d_on_ground", mon_npass), int'(on_ground), mon_e.og);
            check($sformatf("p%0d_latency", mon_npass), mon_lat, mon_e.lat);
          end
          mon_lat = 0;
        end
        mon_prev = busy;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_kid_l", int'(kid_l), 40);
    check("rst_kid_r", int'(kid_r), 51);
    check("rst_kid_t", int'(kid_t), 396);
    check("rst_kid_b", int'(kid_b), 417);
    check("rst_dir", int'(kid_dir), 1);
    check("rst_on_ground", int'(on_ground), 0);
    check("rst_busy", int'(busy), 0);
    @(negedge clk) rst_n = 1'b1;

    // Free fall: vy 1..9 then saturates at 9
    yexp = 396;
    for (int k = 1; k <= 10; k++) begin
      vyexp = (k > 9) ? 9 : k;
      yexp += vyexp;
      do_frame(40, yexp, 1, 0, 4 + vyexp);
    end

    // Landing: floor 4 px below while falling at vy=9
    floor_y  = 475;
    floor_en = 1'b1;
    do_frame(40, 454, 1, 1, 8);

    // Ground jump, air jump, third edge gives gravity, then plain gravity
    tap_jump();
    do_frame(40, 446, 1, 0, 12);
    tap_jump();
    do_frame(40, 439, 1, 0, 11);
    tap_jump();
    do_frame(40, 433, 1, 0, 10);
    do_frame(40, 428, 1, 0, 9);

    // Fresh start standing on a floor at the reset position
    @(negedge clk) rst_n = 1'b0;
    floor_y = 417;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    do_frame(40, 396, 1, 1, 4);

    // Walking: wall after 1 px, left walk, both held, right walk
    wallr_x   = 52;
    wallr_en  = 1'b1;
    btn_right = 1'b1;
    do_frame(41, 396, 1, 1, 5);
    wallr_en  = 1'b0;
    btn_right = 1'b0;
    btn_left  = 1'b1;
    do_frame(38, 396, 0, 1, 7);
    btn_right = 1'b1;
    do_frame(38, 396, 0, 1, 4);
    btn_left  = 1'b0;
    do_frame(41, 396, 1, 1, 7);

    // frame_tick during a pass is dropped
    expect_pass(44, 396, 1, 1, 7);
    tick();
    repeat (2) @(negedge clk);
    check("busy_mid_pass", int'(busy), 1);
    frame_tick = 1'b1;
    @(negedge clk) frame_tick = 1'b0;
    wait_drain();
    repeat (20) @(negedge clk);
    check("idle_after_ignored_tick", int'(busy), 0);

    // Reset in the middle of HMOVE
    tick();
    repeat (2) @(negedge clk);
    check("hmove_first_step", int'(kid_l), 45);
    #2 rst_n = 1'b0;
    #1;
    check("midreset_kid_l", int'(kid_l), 40);
    check("midreset_kid_t", int'(kid_t), 396);
    check("midreset_busy", int'(busy), 0);
    repeat (2) @(negedge clk);
    btn_right = 1'b0;
    rst_n = 1'b1;
    do_frame(40, 396, 1, 1, 4);

    // Left screen clamp at x=0
    btn_left = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      if (k == 14) do_frame(0, 396, 0, 1, 5);
      else         do_frame(40 - 3 * k, 396, 0, 1, 7);
    end
    btn_left = 1'b0;

    // Ceiling 4 px above cuts the jump and zeroes vy
    ceil_y  = 392;
    ceil_en = 1'b1;
    tap_jump();
    do_frame(0, 392, 0, 0, 8);
    do_frame(0, 393, 0, 0, 5);

    check("queue_empty", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
